// File: rtl/arbiter_rr4.sv
`default_nettype none
// ============================================================================
// Module   : arbiter_rr4
// Purpose  : Four-source round-robin merger of upstream FIFOs into one
//            downstream FIFO, with a two-stage pop-to-push pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module arbiter_rr4 (
    input  logic       clk,
    input  logic       RESET_L,
    input  logic [3:0] fifo_empty,
    input  logic [5:0] data_in0,
    input  logic [5:0] data_in1,
    input  logic [5:0] data_in2,
    input  logic [5:0] data_in3,
    input  logic       down_al_full,
    output logic [3:0] fifo_rd,
    output logic       fifo_wr,
    output logic [5:0] data_out,
    output logic [1:0] src_id,
    output logic [1:0] state,
    output logic [7:0] push_cnt
);

    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_ACTIVE = 2'd1;
    localparam logic [1:0] C_ST_DRAIN  = 2'd2;

    logic [1:0] ptr_q,   ptr_d;
    logic [3:0] rd_q,    rd_d;
    logic       v1_q;
    logic [1:0] id1_q,   id1_d;
    logic       wr_q;
    logic [5:0] dout_q;
    logic [1:0] src_q;
    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q;

    logic [3:0] w_eligible;
    logic       w_grant;
    logic [1:0] w_gidx;
    logic [1:0] w_cand;
    logic [5:0] w_sel_data;
    logic       w_inflight;

    // A source popped this cycle is skipped next cycle because its empty flag lags by one.
    always_comb begin
        w_eligible = ~fifo_empty & ~rd_q;
        w_grant    = 1'b0;
        w_gidx     = ptr_q;
        w_cand     = ptr_q;
        if (!down_al_full) begin
            for (int k = 0; k < 4; k++) begin
                w_cand = ptr_q + k[1:0];
                if (!w_grant && w_eligible[w_cand]) begin
                    w_grant = 1'b1;
                    w_gidx  = w_cand;
                end
            end
        end
        rd_d  = w_grant ? (4'b0001 << w_gidx) : 4'b0000;
        ptr_d = w_grant ? (w_gidx + 2'd1) : ptr_q;
    end

    always_comb begin
        case (rd_q)
            4'b0010: id1_d = 2'd1;
            4'b0100: id1_d = 2'd2;
            4'b1000: id1_d = 2'd3;
            default: id1_d = 2'd0;
        endcase
    end

    always_comb begin
        case (id1_q)
            2'd1:    w_sel_data = data_in1;
            2'd2:    w_sel_data = data_in2;
            2'd3:    w_sel_data = data_in3;
            default: w_sel_data = data_in0;
        endcase
    end

    // Words still to be pushed after the coming edge: a pop now, or a captured word.
    assign w_inflight = (|rd_q) | v1_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE:   state_d = w_grant ? C_ST_ACTIVE : C_ST_IDLE;
            C_ST_ACTIVE,
            C_ST_DRAIN: begin
                if (w_grant)         state_d = C_ST_ACTIVE;
                else if (w_inflight) state_d = C_ST_DRAIN;
                else                 state_d = C_ST_IDLE;
            end
            default:     state_d = C_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q <= C_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            ptr_q  <= 2'd0;
            rd_q   <= 4'b0000;
            v1_q   <= 1'b0;
            id1_q  <= 2'd0;
            wr_q   <= 1'b0;
            dout_q <= 6'd0;
            src_q  <= 2'd0;
            cnt_q  <= 8'd0;
        end else begin
            ptr_q <= ptr_d;
            rd_q  <= rd_d;
            v1_q  <= |rd_q;
            id1_q <= id1_d;
            wr_q  <= v1_q;
            if (v1_q) begin
                dout_q <= w_sel_data;
                src_q  <= id1_q;
                if (cnt_q != 8'hFF) begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

    always_comb begin
        fifo_rd  = rd_q;
        fifo_wr  = wr_q;
        data_out = dout_q;
        src_id   = src_q;
        state    = state_q;
        push_cnt = cnt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_arbiter_rr4.sv
`default_nettype none
// ============================================================================
// Module   : tb_arbiter_rr4
// Purpose  : Directed scoreboard bench for arbiter_rr4 with upstream FIFO models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arbiter_rr4;

    logic       clk = 1'b0;
    logic       RESET_L = 1'b1;
    logic [3:0] fifo_empty;
    logic [5:0] data_in0, data_in1, data_in2, data_in3;
    logic       down_al_full = 1'b0;
    logic [3:0] fifo_rd;
    logic       fifo_wr;
    logic [5:0] data_out;
    logic [1:0] src_id;
    logic [1:0] state;
    logic [7:0] push_cnt;

    arbiter_rr4 dut (
        .clk          (clk),
        .RESET_L      (RESET_L),
        .fifo_empty   (fifo_empty),
        .data_in0     (data_in0),
        .data_in1     (data_in1),
        .data_in2     (data_in2),
        .data_in3     (data_in3),
        .down_al_full (down_al_full),
        .fifo_rd      (fifo_rd),
        .fifo_wr      (fifo_wr),
        .data_out     (data_out),
        .src_id       (src_id),
        .state        (state),
        .push_cnt     (push_cnt)
    );

    always #5 clk = ~clk;

    // Upstream FIFO models: written by stimulus (wp), popped by DUT (rp); data registered on pop.
    logic [5:0] mem [4][256];
    int         wp [4];
    int         rp [4];
    logic [5:0] din_r [4];

    assign fifo_empty[0] = (rp[0] == wp[0]);
    assign fifo_empty[1] = (rp[1] == wp[1]);
    assign fifo_empty[2] = (rp[2] == wp[2]);
    assign fifo_empty[3] = (rp[3] == wp[3]);
    assign data_in0 = din_r[0];
    assign data_in1 = din_r[1];
    assign data_in2 = din_r[2];
    assign data_in3 = din_r[3];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (fifo_rd[i] && (rp[i] != wp[i])) begin
                din_r[i] <= mem[i][rp[i] % 256];
                rp[i]    <= rp[i] + 1;
            end
        end
    end

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_wr     = 0;
    logic [7:0] exp_q [$];

    always @(negedge clk) begin
        if (RESET_L && fifo_wr) begin
            logic [7:0] e;
            n_wr++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL push_unexpected: got src=%0d data=%h, required no push", src_id, data_out);
            end else begin
                e = exp_q.pop_front();
                if ({src_id, data_out} !== e[7:0]) begin
                    n_fail++;
                    $display("FAIL push_word: got src=%0d data=%h, required src=%0d data=%h",
                             src_id, data_out, e[7:6], e[5:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic load(input int s, input logic [5:0] d);
        logic [1:0] sid;
        sid = s[1:0];
        mem[s][wp[s] % 256] = d;
        wp[s] = wp[s] + 1;
        exp_q.push_back({sid, d});
    endtask

    task automatic enter_reset();
        @(negedge clk);
        RESET_L = 1'b0;
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        RESET_L = 1'b1;
    endtask

    task automatic step_rd(input string nm, input logic [3:0] exp);
        @(negedge clk);
        chk(nm, {28'd0, fifo_rd}, {28'd0, exp});
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [3:0] seq [5];
        int         wr_before;

        // Power-on reset state
        #2 RESET_L = 1'b0;
        #1;
        chk("rst_fifo_rd",  {28'd0, fifo_rd},  0);
        chk("rst_fifo_wr",  {31'd0, fifo_wr},  0);
        chk("rst_state",    {30'd0, state},    0);
        chk("rst_push_cnt", {24'd0, push_cnt}, 0);
        chk("rst_data_src", {24'd0, src_id, data_out}, 0);

        // All four sources non-empty: strict rotation 0,1,2,3,0
        enter_reset();
        load(0, 6'h01); load(1, 6'h12); load(2, 6'h23); load(3, 6'h34); load(0, 6'h05);
        release_reset();
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step_rd("rr4_fifo_rd", seq[i]);
            if (i == 2) chk("rr4_state_active", {30'd0, state}, 1);
        end
        step_rd("rr4_no_extra_pop", 4'b0000);
        wait_drain("rr4_drain", 50);
        chk("rr4_push_cnt", {24'd0, push_cnt}, 5);
        chk("rr4_state_idle", {30'd0, state}, 0);

        // Single source: one pop every other cycle, never a third
        enter_reset();
        load(2, 6'b010010); load(2, 6'b100100);
        release_reset();
        step_rd("single_rd0", 4'b0100);
        step_rd("single_rd1", 4'b0000);
        step_rd("single_rd2", 4'b0100);
        step_rd("single_rd3", 4'b0000);
        step_rd("single_rd4", 4'b0000);
        step_rd("single_rd5", 4'b0000);
        wait_drain("single_drain", 50);
        chk("single_push_cnt", {24'd0, push_cnt}, 2);

        // Almost-full back-pressure with two words in flight, then resume
        enter_reset();
        for (int k = 0; k < 4; k++) begin
            load(0, 6'h08 + 6'(k));
            load(1, 6'h30 + 6'(k));
        end
        release_reset();
        step_rd("af_rd0", 4'b0001);
        step_rd("af_rd1", 4'b0010);
        down_al_full = 1'b1;
        step_rd("af_stop0", 4'b0000);
        chk("af_state_drain", {30'd0, state}, 2);
        step_rd("af_stop1", 4'b0000);
        step_rd("af_stop2", 4'b0000);
        chk("af_state_idle", {30'd0, state}, 0);
        chk("af_push_cnt", {24'd0, push_cnt}, 2);
        step_rd("af_stop3", 4'b0000);
        down_al_full = 1'b0;
        step_rd("af_resume0", 4'b0001);
        step_rd("af_resume1", 4'b0010);
        wait_drain("af_drain", 50);
        chk("af_push_cnt_end", {24'd0, push_cnt}, 8);

        // Reset one cycle after a pop: asynchronous clear, in-flight word discarded
        @(negedge clk);
        mem[1][wp[1] % 256] = 6'h3F; wp[1] = wp[1] + 1;
        mem[1][wp[1] % 256] = 6'h2A; wp[1] = wp[1] + 1;
        step_rd("mid_rst_pop", 4'b0010);
        @(negedge clk);
        wr_before = n_wr;
        RESET_L = 1'b0;
        #1;
        chk("mid_rst_fifo_rd",  {28'd0, fifo_rd},  0);
        chk("mid_rst_fifo_wr",  {31'd0, fifo_wr},  0);
        chk("mid_rst_data_src", {24'd0, src_id, data_out}, 0);
        chk("mid_rst_state",    {30'd0, state},    0);
        chk("mid_rst_push_cnt", {24'd0, push_cnt}, 0);
        wp[1] = rp[1];
        @(negedge clk);
        release_reset();
        repeat (6) @(negedge clk);
        chk("mid_rst_no_push", n_wr - wr_before, 0);
        chk("mid_rst_cnt_after", {24'd0, push_cnt}, 0);

        // 300 pushes from sources 0 and 3: alternation and counter saturation
        enter_reset();
        for (int k = 0; k < 150; k++) begin
            load(0, 6'(k));
            load(3, 6'(k + 17));
        end
        release_reset();
        wait_drain("sat_drain", 1000);
        chk("sat_push_cnt", {24'd0, push_cnt}, 255);
        chk("sat_state_idle", {30'd0, state}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
